// File: rtl/spd_param.sv
// spd_param: register-exchange survivor path decoder.
// Each state keeps a DEPTH-bit survivor, updated from its ACS decision on
// every accepted input. Once DEPTH inputs have been accepted since reset or
// flush, the oldest bit of the chosen state's survivor is output per input.
// Optional feature macro: SPD_BEST_STATE_EN. When defined, the decoded state
// is the minimum path metric (lowest index on ties). When undefined, state 0
// is always used and pm is ignored.

// Next survivor for one trellis state: select a predecessor, shift, append bit.
module spd_param_lane #(
  parameter int DEPTH = 15
) (
  input  logic [DEPTH-1:0] i_surv_p0,
  input  logic [DEPTH-1:0] i_surv_p1,
  input  logic             i_dec,
  input  logic             i_bit,
  output logic [DEPTH-1:0] o_surv
);
  logic [DEPTH-1:0] w_sel;

  assign w_sel  = i_dec ? i_surv_p1 : i_surv_p0;
  assign o_surv = {w_sel[DEPTH-2:0], i_bit};
endmodule

module spd_param #(
  parameter int NUM_STATES = 4,
  parameter int DEPTH      = 15,
  parameter int PM_WIDTH   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic                           flush,
  input  logic [NUM_STATES-1:0]          dec,
  input  logic [NUM_STATES*PM_WIDTH-1:0] pm,
  output logic                           out_valid,
  output logic                           out_bit,
  output logic [$clog2(NUM_STATES)-1:0]  best_state
);
  localparam int SW = $clog2(NUM_STATES);
  localparam int CW = $clog2(DEPTH + 1);

  logic [NUM_STATES-1:0][DEPTH-1:0] r_surv;
  logic [NUM_STATES-1:0][DEPTH-1:0] w_surv_nxt;
  logic [CW-1:0]                    r_cnt;
  logic [CW-1:0]                    w_cnt_inc;
  logic [SW-1:0]                    w_best;
  logic                             w_accept;
  logic                             r_out_valid;
  logic                             r_out_bit;
  logic [SW-1:0]                    r_best_state;

  assign w_accept = in_valid & ~flush;

  // Fill counter saturates at DEPTH so output stays continuous once full.
  assign w_cnt_inc = (r_cnt == CW'(DEPTH)) ? r_cnt : r_cnt + 1'b1;

  // One exchange lane per state; predecessors are (2s mod N) and that plus one.
  for (genvar s = 0; s < NUM_STATES; s++) begin : g_lane
    localparam int   P0  = (2 * s) % NUM_STATES;
    localparam logic MSB = (s >= NUM_STATES / 2);
    spd_param_lane #(.DEPTH(DEPTH)) u_lane (
      .i_surv_p0 (r_surv[P0]),
      .i_surv_p1 (r_surv[P0+1]),
      .i_dec     (dec[s]),
      .i_bit     (MSB),
      .o_surv    (w_surv_nxt[s])
    );
  end

`ifdef SPD_BEST_STATE_EN
  logic [PM_WIDTH-1:0] w_min;

  // Linear minimum search; strict compare keeps the lowest index on ties.
  always_comb begin
    w_best = '0;
    w_min  = pm[0 +: PM_WIDTH];
    for (int s = 1; s < NUM_STATES; s++) begin
      if (pm[s*PM_WIDTH +: PM_WIDTH] < w_min) begin
        w_min  = pm[s*PM_WIDTH +: PM_WIDTH];
        w_best = SW'(s);
      end
    end
  end
`else
  logic w_unused_pm;

  // Fixed-state decoding: always trace state 0, metrics are not used.
  assign w_best      = '0;
  assign w_unused_pm = ^pm;
`endif

  // Survivors, fill count and registered outputs; flush outranks in_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_surv       <= '0;
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_out_bit    <= 1'b0;
      r_best_state <= '0;
    end else if (flush) begin
      r_surv      <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_surv       <= w_surv_nxt;
      r_cnt        <= w_cnt_inc;
      r_out_valid  <= (w_cnt_inc == CW'(DEPTH));
      r_out_bit    <= w_surv_nxt[w_best][DEPTH-1];
      r_best_state <= w_best;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_bit    = r_out_bit;
  assign best_state = r_best_state;
endmodule
